uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 244 ++++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: 7/8 data bits, none/odd/even/mark parity, 1/2 stop bits.
// Optional line-break forcing with input break_in when UART_TX_BREAK_EN is defined.
//
// state  | meaning
// IDLE   | line high, waiting for a queued byte and enable_in
// START  | start bit (0)
// DATA   | data bits, LSB first
// PARITY | parity bit
// STOP   | one or two stop bits (1)
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 5
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             enable_in,
  input  logic             n_wr_in,
  input  logic [7:0]       data_in,
  input  logic [31:0]      clk_div_baud_in,
  input  logic [1:0]       parity_in,
  input  logic             d_num_in,
  input  logic             s_num_in,
`ifdef UART_TX_BREAK_EN
  input  logic             break_in,
`endif
  output logic             tx_out,
  output logic             tx_rdy_out,
  output logic             tx_busy_out,
  output logic [CNT_W-1:0] fifo_count_out,
  output logic             overflow_error_out
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]       st_q, st_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [31:0]      div_q, div_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       sh_q, sh_d;
  logic             d8_q, d8_d;
  logic             s2_q, s2_d;
  logic             par_en_q, par_en_d;
  logic             par_bit_q, par_bit_d;
  logic             tx_q, tx_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             n_wr_q;
  logic [7:0]       mem [FIFO_DEPTH];

  logic        wr_det, full, push, pop, launch, bit_end, start_ok, brk_ok;
  logic [31:0] div_eff;
  logic [7:0]  head, head_data;

  assign wr_det    = n_wr_q & ~n_wr_in;
  assign full      = (count_q == CNT_W'(FIFO_DEPTH));
  assign div_eff   = (clk_div_baud_in < 32'd2) ? 32'd2 : clk_div_baud_in;
  assign head      = mem[rd_ptr_q];
  assign head_data = d_num_in ? head : {1'b0, head[6:0]};
  assign bit_end   = (cnt_q == 32'd0);

`ifdef UART_TX_BREAK_EN
  // Guard keeps the line idle for one bit time after a break is released.
  logic [31:0] guard_q, guard_d;

  always_comb begin
    guard_d = guard_q;
    if (break_in)
      guard_d = div_eff - 32'd1;
    else if (guard_q != 32'd0)
      guard_d = guard_q - 32'd1;
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) guard_q <= 32'd0;
    else          guard_q <= guard_d;
  end

  assign brk_ok = ~break_in & (guard_q == 32'd0);
  assign tx_out = break_in ? 1'b0 : tx_q;
`else
  assign brk_ok = 1'b1;
  assign tx_out = tx_q;
`endif

  assign start_ok = (count_q != '0) & enable_in & brk_ok;

  always_comb begin
    st_d      = st_q;
    cnt_d     = bit_end ? cnt_q : cnt_q - 32'd1;
    div_d     = div_q;
    idx_d     = idx_q;
    sh_d      = sh_q;
    d8_d      = d8_q;
    s2_d      = s2_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    tx_d      = tx_q;
    launch    = 1'b0;
    case (st_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (start_ok) launch = 1'b1;
      end
      S_START: begin
        if (bit_end) begin
          st_d  = S_DATA;
          tx_d  = sh_q[0];
          idx_d = 3'd0;
          cnt_d = div_q - 32'd1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = div_q - 32'd1;
          if (idx_q == (d8_q ? 3'd7 : 3'd6)) begin
            idx_d = 3'd0;
            if (par_en_q) begin
              st_d = S_PARITY;
              tx_d = par_bit_q;
            end else begin
              st_d = S_STOP;
              tx_d = 1'b1;
            end
          end else begin
            idx_d = idx_q + 3'd1;
            sh_d  = {1'b0, sh_q[7:1]};
            tx_d  = sh_q[1];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          st_d  = S_STOP;
          tx_d  = 1'b1;
          idx_d = 3'd0;
          cnt_d = div_q - 32'd1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (s2_q && idx_q == 3'd0) begin
            idx_d = 3'd1;
            cnt_d = div_q - 32'd1;
          end else if (start_ok) begin
            launch = 1'b1;
          end else begin
            st_d = S_IDLE;
            tx_d = 1'b1;
          end
        end
      end
      default: begin
        st_d = S_IDLE;
        tx_d = 1'b1;
      end
    endcase

    // Frame configuration is captured with the popped byte and held until the frame ends.
    if (launch) begin
      st_d     = S_START;
      tx_d     = 1'b0;
      sh_d     = head;
      d8_d     = d_num_in;
      s2_d     = s_num_in;
      par_en_d = (parity_in != 2'b00);
      case (parity_in)
        2'b01:   par_bit_d = ~^head_data;
        2'b10:   par_bit_d = ^head_data;
        default: par_bit_d = 1'b1;
      endcase
      div_d = div_eff;
      cnt_d = div_eff - 32'd1;
      idx_d = 3'd0;
    end
  end

  assign pop  = launch;
  assign push = wr_det & (~full | pop);

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    ovf_d    = ovf_q | (wr_det & ~push);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (push && !reset_in) mem[wr_ptr_q] <= data_in;
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      st_q      <= S_IDLE;
      cnt_q     <= 32'd0;
      div_q     <= 32'd2;
      idx_q     <= 3'd0;
      sh_q      <= 8'd0;
      d8_q      <= 1'b1;
      s2_q      <= 1'b0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      n_wr_q    <= 1'b1;
    end else begin
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      idx_q     <= idx_d;
      sh_q      <= sh_d;
      d8_q      <= d8_d;
      s2_q      <= s2_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      n_wr_q    <= n_wr_in;
    end
  end

  assign tx_rdy_out         = ~full;
  assign tx_busy_out        = (st_q != S_IDLE) | (count_q != '0);
  assign fifo_count_out     = count_q;
  assign overflow_error_out = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed frames plus randomized frames against a
// bit-list model of the serial line built from the framing rules.
module tb_uart_tx_fifo;

  logic        clk_in = 1'b0;
  logic        reset_in, enable_in, n_wr_in, d_num_in, s_num_in;
  logic [7:0]  data_in;
  logic [31:0] clk_div_baud_in;
  logic [1:0]  parity_in;
  logic        tx_out, tx_rdy_out, tx_busy_out, overflow_error_out;
  logic [4:0]  fifo_count_out;

  int checks = 0;
  int failures = 0;

  uart_tx_fifo dut (
    .clk_in             (clk_in),
    .reset_in           (reset_in),
    .enable_in          (enable_in),
    .n_wr_in            (n_wr_in),
    .data_in            (data_in),
    .clk_div_baud_in    (clk_div_baud_in),
    .parity_in          (parity_in),
    .d_num_in           (d_num_in),
    .s_num_in           (s_num_in),
    .tx_out             (tx_out),
    .tx_rdy_out         (tx_rdy_out),
    .tx_busy_out        (tx_busy_out),
    .fifo_count_out     (fifo_count_out),
    .overflow_error_out (overflow_error_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Serial line model: start, data LSB first, optional parity, stop bits; bits[0] goes first.
  function automatic int frame_bits(input logic [7:0] b, input logic [1:0] par,
                                    input logic d8, input logic s2, output logic [15:0] bits);
    int n, nd, ones;
    bits = '0;
    n = 0;
    bits[n] = 1'b0; n = n + 1;
    nd = d8 ? 8 : 7;
    ones = 0;
    for (int i = 0; i < nd; i++) begin
      bits[n] = b[i];
      n = n + 1;
      if (b[i]) ones = ones + 1;
    end
    if (par != 2'b00) begin
      if (par == 2'b01)      bits[n] = (ones % 2 == 0);
      else if (par == 2'b10) bits[n] = (ones % 2 == 1);
      else                   bits[n] = 1'b1;
      n = n + 1;
    end
    bits[n] = 1'b1; n = n + 1;
    if (s2) begin bits[n] = 1'b1; n = n + 1; end
    return n;
  endfunction

  // Every cycle of every bit must match; one comparison per bit.
  task automatic expect_bits(input string tag, input logic [15:0] bits, input int len, input int div);
    logic obs;
    for (int i = 0; i < len; i++) begin
      obs = bits[i];
      repeat (div) begin
        @(negedge clk_in);
        if (tx_out !== bits[i]) obs = tx_out;
      end
      chk(tag, {31'd0, obs}, {31'd0, bits[i]});
    end
  endtask

  task automatic check_idle(input string tag, input int n);
    logic obs;
    obs = 1'b1;
    repeat (n) begin
      @(negedge clk_in);
      if (tx_out !== 1'b1) obs = tx_out;
    end
    chk(tag, {31'd0, obs}, 32'd1);
  endtask

  task automatic write_byte(input logic [7:0] b);
    data_in = b;
    n_wr_in = 1'b0;
    @(negedge clk_in);
    n_wr_in = 1'b1;
  endtask

  task automatic do_reset();
    reset_in = 1'b1;
    n_wr_in  = 1'b1;
    repeat (2) @(negedge clk_in);
    reset_in = 1'b0;
  endtask

  function automatic int eff_div(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  logic [15:0] fb, lit;
  int          nb, rd, rk;
  logic [1:0]  rp;
  logic        rd8, rs2;
  logic [7:0]  rb [3];

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_in = 1'b1; enable_in = 1'b1; n_wr_in = 1'b1; data_in = 8'h00;
    clk_div_baud_in = 32'd4; parity_in = 2'b00; d_num_in = 1'b1; s_num_in = 1'b0;
    repeat (3) @(negedge clk_in);
    reset_in = 1'b0;
    chk("rst_tx", tx_out, 1);
    chk("rst_rdy", tx_rdy_out, 1);
    chk("rst_busy", tx_busy_out, 0);
    chk("rst_count", fifo_count_out, 0);
    chk("rst_ovf", overflow_error_out, 0);

    // 8N1 0xA5, configuration scrambled mid-frame must not disturb it
    write_byte(8'hA5);
    lit = 16'b0000001101001010;
    fork
      expect_bits("a5_8n1", lit, 10, 4);
      begin
        repeat (6) @(negedge clk_in);
        parity_in = 2'b11; d_num_in = 1'b0; s_num_in = 1'b1; clk_div_baud_in = 32'd9;
      end
    join
    check_idle("a5_idle", 8);
    chk("a5_busy", tx_busy_out, 0);

    // 7E2 0xC3: bit 7 dropped, even parity bit is 1
    clk_div_baud_in = 32'd4; parity_in = 2'b10; d_num_in = 1'b0; s_num_in = 1'b1;
    write_byte(8'hC3);
    lit = 16'b0000011110000110;
    expect_bits("c3_7e2", lit, 11, 4);
    check_idle("c3_idle", 8);

    // burst of 18 writes into a 16-deep FIFO during the first frame
    clk_div_baud_in = 32'd4; parity_in = 2'b00; d_num_in = 1'b1; s_num_in = 1'b0;
    fork
      begin
        for (int j = 0; j < 18; j++) begin
          write_byte(j[7:0]);
          if (j == 16) begin
            chk("burst_count16", fifo_count_out, 16);
            chk("burst_rdy_full", tx_rdy_out, 0);
            chk("burst_ovf_pre", overflow_error_out, 0);
          end
          @(negedge clk_in);
        end
        chk("burst_ovf", overflow_error_out, 1);
        chk("burst_count_after_drop", fifo_count_out, 16);
      end
      begin
        @(negedge clk_in);
        for (int j = 0; j < 17; j++) begin
          nb = frame_bits(j[7:0], 2'b00, 1'b1, 1'b0, fb);
          expect_bits("burst_frame", fb, nb, 4);
        end
      end
    join
    check_idle("burst_idle", 8);
    chk("burst_ovf_sticky", overflow_error_out, 1);
    chk("burst_empty", fifo_count_out, 0);
    do_reset();
    chk("ovf_cleared", overflow_error_out, 0);

    // long write pulse, then enable gating with 3 bytes queued
    clk_div_baud_in = 32'd3; parity_in = 2'b01; d_num_in = 1'b1; s_num_in = 1'b0;
    enable_in = 1'b0;
    data_in = 8'h3C;
    n_wr_in = 1'b0;
    repeat (50) @(negedge clk_in);
    n_wr_in = 1'b1;
    @(negedge clk_in);
    chk("long_pulse_count", fifo_count_out, 1);
    write_byte(8'h81); @(negedge clk_in);
    write_byte(8'h7E); @(negedge clk_in);
    chk("en0_count", fifo_count_out, 3);
    check_idle("en0_line_high", 10);
    chk("en0_count_hold", fifo_count_out, 3);
    chk("en0_busy", tx_busy_out, 1);
    enable_in = 1'b1;
    nb = frame_bits(8'h3C, 2'b01, 1'b1, 1'b0, fb); expect_bits("en1_frame0", fb, nb, 3);
    nb = frame_bits(8'h81, 2'b01, 1'b1, 1'b0, fb); expect_bits("en1_frame1", fb, nb, 3);
    nb = frame_bits(8'h7E, 2'b01, 1'b1, 1'b0, fb); expect_bits("en1_frame2", fb, nb, 3);
    check_idle("en1_idle", 6);

    // reset mid-DATA truncates the frame; a write during reset is discarded
    clk_div_baud_in = 32'd4; parity_in = 2'b00; d_num_in = 1'b1; s_num_in = 1'b0;
    write_byte(8'h55);
    @(negedge clk_in);
    write_byte(8'h12);
    repeat (5) @(negedge clk_in);
    chk("pre_rst_busy", tx_busy_out, 1);
    reset_in = 1'b1;
    data_in  = 8'hEE;
    n_wr_in  = 1'b0;
    @(negedge clk_in);
    chk("midrst_tx", tx_out, 1);
    chk("midrst_count", fifo_count_out, 0);
    chk("midrst_rdy", tx_rdy_out, 1);
    chk("midrst_busy", tx_busy_out, 0);
    reset_in = 1'b0;
    n_wr_in  = 1'b1;
    check_idle("postrst_idle", 12);
    chk("postrst_count", fifo_count_out, 0);

    // randomized frames against the line model
    for (int it = 0; it < 15; it++) begin
      rd  = (it == 0) ? 0 : (it == 1) ? 1 : int'($urandom_range(2, 6));
      rp  = 2'($urandom_range(0, 3));
      rd8 = 1'($urandom_range(0, 1));
      rs2 = 1'($urandom_range(0, 1));
      rk  = int'($urandom_range(1, 3));
      for (int j = 0; j < 3; j++) rb[j] = 8'($urandom);
      clk_div_baud_in = rd; parity_in = rp; d_num_in = rd8; s_num_in = rs2;
      fork
        begin
          for (int j = 0; j < rk; j++) begin
            write_byte(rb[j]);
            @(negedge clk_in);
          end
        end
        begin
          @(negedge clk_in);
          for (int j = 0; j < rk; j++) begin
            nb = frame_bits(rb[j], rp, rd8, rs2, fb);
            expect_bits("rand_frame", fb, nb, eff_div(rd));
          end
        end
      join
      check_idle("rand_idle", 4);
      chk("rand_busy", tx_busy_out, 0);
      chk("rand_count", fifo_count_out, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
